// File: rtl/fp_lt_stream_cmp_pkg.sv
// rtl/fp_lt_stream_cmp_pkg.sv - FP32 field constants, relation encoding and field helpers
package fp_lt_stream_cmp_pkg;

  localparam int SIGN_BIT = 31;
  localparam int EXP_MSB  = 30;
  localparam int EXP_LSB  = 23;
  localparam int MANT_MSB = 22;
  localparam int MANT_LSB = 0;
  localparam int MAG_W    = 31;
  localparam logic [7:0] EXP_ALL_ONES = 8'hFF;

  typedef enum logic [1:0] {
    LESS      = 2'd0,
    EQUAL     = 2'd1,
    GREATER   = 2'd2,
    UNORDERED = 2'd3
  } fp_rel_e;

  function automatic logic fp_is_nan(input logic [31:0] v);
    return (v[EXP_MSB:EXP_LSB] == EXP_ALL_ONES) && (v[MANT_MSB:MANT_LSB] != '0);
  endfunction

  function automatic logic fp_is_zero(input logic [31:0] v);
    return v[MAG_W-1:0] == '0;
  endfunction

endpackage

// File: rtl/fp32_mag_cmp.sv
// rtl/fp32_mag_cmp.sv - combinational unsigned compare of two 31-bit {exp,mant} magnitudes
module fp32_mag_cmp
  import fp_lt_stream_cmp_pkg::*;
(
  input  logic [MAG_W-1:0] mag_a,
  input  logic [MAG_W-1:0] mag_b,
  output logic             mag_gt,
  output logic             mag_eq
);

  // Biased exponent above mantissa makes the integer order equal the float magnitude order,
  // including denormals and infinities.
  assign mag_gt = (mag_a > mag_b);
  assign mag_eq = (mag_a == mag_b);

endmodule

// File: rtl/fp_lt_stream_cmp.sv
// rtl/fp_lt_stream_cmp.sv - 2-stage streaming FP32 compare; FP_CMP_NAN_EN enables NaN -> unordered
module fp_lt_stream_cmp
  import fp_lt_stream_cmp_pkg::*;
#(
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_less,
  output logic             out_equal,
  output logic             out_greater,
  output logic             out_unordered,
  output logic [TAG_W-1:0] out_tag
);

  logic             s1_valid;
  logic             s1_sign_a;
  logic             s1_sign_b;
  logic             s1_both_zero;
  logic             s1_mag_gt;
  logic             s1_mag_eq;
  logic [TAG_W-1:0] s1_tag;
  logic             mag_gt;
  logic             mag_eq;
  logic             s2_ready;
  fp_rel_e          rel;

  fp32_mag_cmp u_mag_cmp (
    .mag_a  (in_a[MAG_W-1:0]),
    .mag_b  (in_b[MAG_W-1:0]),
    .mag_gt (mag_gt),
    .mag_eq (mag_eq)
  );

  assign s2_ready = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid     <= 1'b0;
      s1_sign_a    <= 1'b0;
      s1_sign_b    <= 1'b0;
      s1_both_zero <= 1'b0;
      s1_mag_gt    <= 1'b0;
      s1_mag_eq    <= 1'b0;
      s1_tag       <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sign_a    <= in_a[SIGN_BIT];
        s1_sign_b    <= in_b[SIGN_BIT];
        s1_both_zero <= fp_is_zero(in_a) && fp_is_zero(in_b);
        s1_mag_gt    <= mag_gt;
        s1_mag_eq    <= mag_eq;
        s1_tag       <= in_tag;
      end
    end
  end

`ifdef FP_CMP_NAN_EN
  logic s1_nan;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_nan <= 1'b0;
    end else if (in_ready && in_valid) begin
      s1_nan <= fp_is_nan(in_a) || fp_is_nan(in_b);
    end
  end
`endif

  // Same-sign magnitude order is flipped when both are negative.
  always_comb begin
    rel = LESS;
    if (s1_both_zero || ((s1_sign_a == s1_sign_b) && s1_mag_eq)) begin
      rel = EQUAL;
    end else if (s1_sign_a != s1_sign_b) begin
      rel = s1_sign_a ? LESS : GREATER;
    end else if (s1_mag_gt ^ s1_sign_a) begin
      rel = GREATER;
    end
`ifdef FP_CMP_NAN_EN
    if (s1_nan) begin
      rel = UNORDERED;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_less    <= 1'b0;
      out_equal   <= 1'b0;
      out_greater <= 1'b0;
      out_tag     <= '0;
    end else if (s2_ready) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_less    <= (rel == LESS);
        out_equal   <= (rel == EQUAL);
        out_greater <= (rel == GREATER);
        out_tag     <= s1_tag;
      end
    end
  end

`ifdef FP_CMP_NAN_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_unordered <= 1'b0;
    end else if (s2_ready && s1_valid) begin
      out_unordered <= (rel == UNORDERED);
    end
  end
`else
  assign out_unordered = 1'b0;
`endif

endmodule

// File: doc/fp_lt_stream_cmp.md
FP_LT_STREAM_CMP -- requirements
Module: fp_lt_stream_cmp

Interface
REQ-001 SHALL have parameter TAG_W, default 8, width of the opaque tag (neuron index) carried with each operand pair.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port in_valid, input, 1, operand pair present.
REQ-005 SHALL have port in_ready, output, 1, block accepts a pair this cycle.
REQ-006 SHALL have port in_a, input, 32, IEEE-754 single-precision operand A.
REQ-007 SHALL have port in_b, input, 32, IEEE-754 single-precision operand B.
REQ-008 SHALL have port in_tag, input, TAG_W, tag travelling with the pair.
REQ-009 SHALL have port out_valid, output, 1, result present.
REQ-010 SHALL have port out_ready, input, 1, downstream accepts the result.
REQ-011 SHALL have ports out_less, out_equal, out_greater, out_unordered, output, 1 each, relation of A to B; exactly one is high whenever out_valid=1.
REQ-012 SHALL have port out_tag, output, TAG_W, tag of the reported pair.

Function
REQ-013 SHALL accept a pair when in_valid and in_ready are both high; SHALL emit a result when out_valid and out_ready are both high.
REQ-014 SHALL be a 2-stage pipeline: S1 registers unpacked fields plus the magnitude compare; S2 registers the sign-resolved result. Latency is 2 cycles from acceptance to out_valid with no backpressure.
REQ-015 SHALL sustain one pair per cycle while out_ready=1.
REQ-016 S1 advances when S2 is empty or S2 is being consumed; in_ready = !S1_valid || S1 advances; in_ready SHALL NOT depend combinationally on in_valid.
REQ-017 SHALL hold out_* stable while out_valid=1 and out_ready=0.
REQ-018 Equal: bit-identical operands, or both operands zero regardless of sign (+0 == -0).
REQ-019 Signs differ (not both zero): the negative operand is less.
REQ-020 Both positive: larger magnitude {exp,mant} is greater. Both negative: the relation is inverted.
REQ-021 Denormals SHALL be compared exactly, with no flush-to-zero. Infinities SHALL order as the largest magnitudes.
REQ-022 No arithmetic subtractor SHALL be used; the compare is integer on the 31-bit magnitude.
REQ-023 On simultaneous accept and emit with a full pipeline, no data SHALL be lost or duplicated.

Reset
REQ-024 While rst_n=0: S1_valid=S2_valid=0, out_valid=0, in_ready=1, and out_less, out_equal, out_greater, out_unordered and out_tag are all 0.
REQ-025 Reset asserted mid-operation SHALL discard all in-flight pairs. The first acceptance after release produces a result 2 cycles later.

Configuration
REQ-026 Macro FP_CMP_NAN_EN SHALL control NaN handling.
- Defined: a pair where either operand has exp=0xFF and mant!=0 SHALL report out_unordered=1 only.
- Undefined: NaNs SHALL be ordered as ordinary magnitudes per REQ-019/020, and out_unordered SHALL be tied to 0.

Structure
REQ-027 A shared package SHALL hold:
- the FP32 field constants: sign bit 31, exponent [30:23], mantissa [22:0], EXP_ALL_ONES=8'hFF;
- a result encoding type: LESS, EQUAL, GREATER, UNORDERED.
REQ-028 One combinational sub-module, fp32_mag_cmp, SHALL compare two 31-bit magnitudes and output mag_gt and mag_eq; it is used in S1.

Verification
REQ-029 A=0x3F800000 (1.0), B=0x40000000 (2.0), tag 5, out_ready=1 -> 2 cycles later out_less=1, out_tag=5.
REQ-030 A=0x80000000 (-0), B=0x00000000 (+0) -> out_equal=1. A=0xBF800000 (-1.0), B=0xC0000000 (-2.0) -> out_greater=1.
REQ-031 A=0x7FC00000 (NaN), B=0x3F800000 -> out_unordered=1 with FP_CMP_NAN_EN defined; out_greater=1 without it.
REQ-032 Backpressure: send 4 back-to-back pairs with out_ready=0 for 6 cycles.
- After 2 pairs are accepted, in_ready=0 and out_* stay stable.
- When out_ready is released, all 4 results emerge in order, with no loss or duplication.
REQ-033 Drive rst_n=0 for 1 cycle while 2 pairs are in flight -> out_valid=0 immediately and no stale result appears. A new pair 0x00000001 vs 0x00000002 (denormals) then yields out_less=1 after 2 cycles.
